instenc: RTL and testbench

INSTENC -- requirements
Module: instenc

---
 rtl/instenc_pkg.sv | 121 ++++++++++++
 rtl/mnem_lookup.sv | 75 +++++++
 rtl/instenc.sv | 81 ++++++++
 tb/tb_instenc.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instenc_pkg.sv
// Shared widths, MIPS32 encoding constants, lookup payload types and the word encoder.
package instenc_pkg;

    localparam int unsigned MNEM_W   = 40;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned IMM_W    = 26;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned ERRCNT_W = 8;
    localparam int unsigned OP_W     = 6;

    // Major opcodes
    localparam logic [OP_W-1:0] EXE_SPECIAL = 6'b000000;
    localparam logic [OP_W-1:0] EXE_REGIMM  = 6'b000001;
    localparam logic [OP_W-1:0] EXE_J       = 6'b000010;
    localparam logic [OP_W-1:0] EXE_JAL     = 6'b000011;
    localparam logic [OP_W-1:0] EXE_BEQ     = 6'b000100;
    localparam logic [OP_W-1:0] EXE_BNE     = 6'b000101;
    localparam logic [OP_W-1:0] EXE_BLEZ    = 6'b000110;
    localparam logic [OP_W-1:0] EXE_BGTZ    = 6'b000111;
    localparam logic [OP_W-1:0] EXE_ADDI    = 6'b001000;
    localparam logic [OP_W-1:0] EXE_ADDIU   = 6'b001001;
    localparam logic [OP_W-1:0] EXE_SLTI    = 6'b001010;
    localparam logic [OP_W-1:0] EXE_SLTIU   = 6'b001011;
    localparam logic [OP_W-1:0] EXE_ANDI    = 6'b001100;
    localparam logic [OP_W-1:0] EXE_ORI     = 6'b001101;
    localparam logic [OP_W-1:0] EXE_XORI    = 6'b001110;
    localparam logic [OP_W-1:0] EXE_LUI     = 6'b001111;
    localparam logic [OP_W-1:0] EXE_COP0    = 6'b010000;
    localparam logic [OP_W-1:0] EXE_LB      = 6'b100000;
    localparam logic [OP_W-1:0] EXE_LH      = 6'b100001;
    localparam logic [OP_W-1:0] EXE_LW      = 6'b100011;
    localparam logic [OP_W-1:0] EXE_LBU     = 6'b100100;
    localparam logic [OP_W-1:0] EXE_LHU     = 6'b100101;
    localparam logic [OP_W-1:0] EXE_SB      = 6'b101000;
    localparam logic [OP_W-1:0] EXE_SH      = 6'b101001;
    localparam logic [OP_W-1:0] EXE_SW      = 6'b101011;

    // SPECIAL funct codes
    localparam logic [OP_W-1:0] EXE_SLL     = 6'b000000;
    localparam logic [OP_W-1:0] EXE_SRL     = 6'b000010;
    localparam logic [OP_W-1:0] EXE_SRA     = 6'b000011;
    localparam logic [OP_W-1:0] EXE_SLLV    = 6'b000100;
    localparam logic [OP_W-1:0] EXE_SRLV    = 6'b000110;
    localparam logic [OP_W-1:0] EXE_SRAV    = 6'b000111;
    localparam logic [OP_W-1:0] EXE_JR      = 6'b001000;
    localparam logic [OP_W-1:0] EXE_JALR    = 6'b001001;
    localparam logic [OP_W-1:0] EXE_SYSCALL = 6'b001100;
    localparam logic [OP_W-1:0] EXE_BREAK   = 6'b001101;
    localparam logic [OP_W-1:0] EXE_MFHI    = 6'b010000;
    localparam logic [OP_W-1:0] EXE_MTHI    = 6'b010001;
    localparam logic [OP_W-1:0] EXE_MFLO    = 6'b010010;
    localparam logic [OP_W-1:0] EXE_MTLO    = 6'b010011;
    localparam logic [OP_W-1:0] EXE_MULT    = 6'b011000;
    localparam logic [OP_W-1:0] EXE_MULTU   = 6'b011001;
    localparam logic [OP_W-1:0] EXE_DIV     = 6'b011010;
    localparam logic [OP_W-1:0] EXE_DIVU    = 6'b011011;
    localparam logic [OP_W-1:0] EXE_ADD     = 6'b100000;
    localparam logic [OP_W-1:0] EXE_ADDU    = 6'b100001;
    localparam logic [OP_W-1:0] EXE_SUB     = 6'b100010;
    localparam logic [OP_W-1:0] EXE_SUBU    = 6'b100011;
    localparam logic [OP_W-1:0] EXE_AND     = 6'b100100;
    localparam logic [OP_W-1:0] EXE_OR      = 6'b100101;
    localparam logic [OP_W-1:0] EXE_XOR     = 6'b100110;
    localparam logic [OP_W-1:0] EXE_NOR     = 6'b100111;
    localparam logic [OP_W-1:0] EXE_SLT     = 6'b101010;
    localparam logic [OP_W-1:0] EXE_SLTU    = 6'b101011;

    // REGIMM rt codes and COP0 rs codes
    localparam logic [REG_W-1:0] EXE_BLTZ   = 5'b00000;
    localparam logic [REG_W-1:0] EXE_BGEZ   = 5'b00001;
    localparam logic [REG_W-1:0] EXE_BLTZAL = 5'b10000;
    localparam logic [REG_W-1:0] EXE_BGEZAL = 5'b10001;
    localparam logic [REG_W-1:0] EXE_MFC0   = 5'b00000;
    localparam logic [REG_W-1:0] EXE_MTC0   = 5'b00100;

    localparam logic [INSTR_W-1:0] EXE_ERET_WORD = 32'h42000018;

    typedef enum logic [2:0] {
        FMT_NOP, FMT_R, FMT_TRAP, FMT_I, FMT_J, FMT_REGIMM, FMT_COP0, FMT_ERET
    } fmt_e;

    typedef struct packed {
        fmt_e            fmt;
        logic [OP_W-1:0] op;
        logic [OP_W-1:0] code;
        logic            err;
    } lookup_t;

    typedef struct packed {
        logic [MNEM_W-1:0] mnem;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  sa;
        logic [IMM_W-1:0]  imm;
    } fields_t;

    // Build a recognised lookup entry.
    function automatic lookup_t lk_mk(fmt_e fmt, logic [OP_W-1:0] op, logic [OP_W-1:0] code);
        return '{fmt: fmt, op: op, code: code, err: 1'b0};
    endfunction

    // Assemble the final word from the lookup result and the operand fields.
    function automatic logic [INSTR_W-1:0] encode(lookup_t lk, fields_t f);
        logic [INSTR_W-1:0] w;
        w = '0;
        case (lk.fmt)
            FMT_R:      w = {EXE_SPECIAL, f.rs, f.rt, f.rd, f.sa, lk.code};
            FMT_TRAP:   w = {EXE_SPECIAL, 20'd0, lk.code};
            FMT_I:      w = {lk.op, f.rs, f.rt, f.imm[15:0]};
            FMT_J:      w = {lk.op, f.imm};
            FMT_REGIMM: w = {lk.op, f.rs, lk.code[REG_W-1:0], f.imm[15:0]};
            FMT_COP0:   w = {lk.op, lk.code[REG_W-1:0], f.rt, f.rd, 11'd0};
            FMT_ERET:   w = EXE_ERET_WORD;
            default:    w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mnem_lookup.sv
// Combinational mnemonic decoder: ASCII mnemonic -> format class, opcode, funct/rt code, error.
module mnem_lookup
    import instenc_pkg::*;
(
    input  logic [MNEM_W-1:0] mnem,
    output lookup_t           lk
);

    // Table lookup; unknown mnemonics encode as zero with err set.
    always_comb begin
        lk = '{fmt: FMT_NOP, op: '0, code: '0, err: 1'b1};
        case (mnem)
            40'("AND"):    lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_AND);
            40'("OR"):     lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_OR);
            40'("XOR"):    lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_XOR);
            40'("NOR"):    lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_NOR);
            40'("SLL"):    lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_SLL);
            40'("SRL"):    lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_SRL);
            40'("SRA"):    lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_SRA);
            40'("SLLV"):   lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_SLLV);
            40'("SRLV"):   lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_SRLV);
            40'("SRAV"):   lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_SRAV);
            40'("MFHI"):   lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_MFHI);
            40'("MTHI"):   lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_MTHI);
            40'("MFLO"):   lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_MFLO);
            40'("MTLO"):   lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_MTLO);
            40'("ADD"):    lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_ADD);
            40'("ADDU"):   lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_ADDU);
            40'("SUB"):    lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_SUB);
            40'("SUBU"):   lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_SUBU);
            40'("SLT"):    lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_SLT);
            40'("SLTU"):   lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_SLTU);
            40'("MULT"):   lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_MULT);
            40'("MULTU"):  lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_MULTU);
            40'("DIV"):    lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_DIV);
            40'("DIVU"):   lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_DIVU);
            40'("JR"):     lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_JR);
            40'("JALR"):   lk = lk_mk(FMT_R, EXE_SPECIAL, EXE_JALR);
            40'("SYSC"):   lk = lk_mk(FMT_TRAP, EXE_SPECIAL, EXE_SYSCALL);
            40'("BRE"):    lk = lk_mk(FMT_TRAP, EXE_SPECIAL, EXE_BREAK);
            40'("ANDI"):   lk = lk_mk(FMT_I, EXE_ANDI, '0);
            40'("XORI"):   lk = lk_mk(FMT_I, EXE_XORI, '0);
            40'("LUI"):    lk = lk_mk(FMT_I, EXE_LUI, '0);
            40'("ORI"):    lk = lk_mk(FMT_I, EXE_ORI, '0);
            40'("ADDI"):   lk = lk_mk(FMT_I, EXE_ADDI, '0);
            40'("ADDIU"):  lk = lk_mk(FMT_I, EXE_ADDIU, '0);
            40'("SLTI"):   lk = lk_mk(FMT_I, EXE_SLTI, '0);
            40'("SLTIU"):  lk = lk_mk(FMT_I, EXE_SLTIU, '0);
            40'("BEQ"):    lk = lk_mk(FMT_I, EXE_BEQ, '0);
            40'("BNE"):    lk = lk_mk(FMT_I, EXE_BNE, '0);
            40'("BGTZ"):   lk = lk_mk(FMT_I, EXE_BGTZ, '0);
            40'("BLEZ"):   lk = lk_mk(FMT_I, EXE_BLEZ, '0);
            40'("LB"):     lk = lk_mk(FMT_I, EXE_LB, '0);
            40'("LBU"):    lk = lk_mk(FMT_I, EXE_LBU, '0);
            40'("LH"):     lk = lk_mk(FMT_I, EXE_LH, '0);
            40'("LHU"):    lk = lk_mk(FMT_I, EXE_LHU, '0);
            40'("LW"):     lk = lk_mk(FMT_I, EXE_LW, '0);
            40'("SB"):     lk = lk_mk(FMT_I, EXE_SB, '0);
            40'("SH"):     lk = lk_mk(FMT_I, EXE_SH, '0);
            40'("SW"):     lk = lk_mk(FMT_I, EXE_SW, '0);
            40'("J"):      lk = lk_mk(FMT_J, EXE_J, '0);
            40'("JAL"):    lk = lk_mk(FMT_J, EXE_JAL, '0);
            40'("BGEZ"):   lk = lk_mk(FMT_REGIMM, EXE_REGIMM, 6'(EXE_BGEZ));
            40'("BGEZAL"): lk = lk_mk(FMT_REGIMM, EXE_REGIMM, 6'(EXE_BGEZAL));
            40'("BLTZ"):   lk = lk_mk(FMT_REGIMM, EXE_REGIMM, 6'(EXE_BLTZ));
            40'("BLTZAL"): lk = lk_mk(FMT_REGIMM, EXE_REGIMM, 6'(EXE_BLTZAL));
            40'("MTOC0"):  lk = lk_mk(FMT_COP0, EXE_COP0, 6'(EXE_MTC0));
            40'("MFC0"):   lk = lk_mk(FMT_COP0, EXE_COP0, 6'(EXE_MFC0));
            40'("ERET"):   lk = lk_mk(FMT_ERET, EXE_COP0, '0);
            40'("NOP"):    lk = lk_mk(FMT_NOP, EXE_SPECIAL, '0);
            default:       lk = '{fmt: FMT_NOP, op: '0, code: '0, err: 1'b1};
        endcase
    end

endmodule

// File: rtl/instenc.sv
// Two-stage valid/ready MIPS32 instruction encoder with output address and error counter.
module instenc
    import instenc_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MNEM_W-1:0]   in_mnem,
    input  logic [REG_W-1:0]    in_rs,
    input  logic [REG_W-1:0]    in_rt,
    input  logic [REG_W-1:0]    in_rd,
    input  logic [REG_W-1:0]    in_sa,
    input  logic [IMM_W-1:0]    in_imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic                out_err,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [ERRCNT_W-1:0] err_cnt
);

    logic    s1_valid;
    fields_t s1_q;
    fields_t in_f;
    lookup_t lk;
    logic    s2_adv;
    logic    out_xfer;

    assign in_f     = '{mnem: in_mnem, rs: in_rs, rt: in_rt, rd: in_rd, sa: in_sa, imm: in_imm};
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign out_xfer = out_valid && out_ready;

    mnem_lookup u_lookup (
        .mnem (s1_q.mnem),
        .lk   (lk)
    );

    // Stage 1: capture the incoming field set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= in_f;
            end
        end
    end

    // Stage 2: register the encoded word; held while downstream stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= encode(lk, s1_q);
                out_err   <= lk.err;
            end
        end
    end

    // Output word index (wraps naturally) and saturating error count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_addr <= '0;
            err_cnt  <= '0;
        end else if (out_xfer) begin
            out_addr <= out_addr + ADDR_W'(1);
            if (out_err && (err_cnt != {ERRCNT_W{1'b1}})) begin
                err_cnt <= err_cnt + ERRCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instenc.sv
// Directed self-checking bench for instenc.
module tb_instenc;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] in_mnem;
    logic [4:0]  in_rs, in_rt, in_rd, in_sa;
    logic [25:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [9:0]  out_addr;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int exp_addr = 0;
    int exp_ecnt = 0;

    always #5 clk = ~clk;

    instenc dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mnem   (in_mnem),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_sa     (in_sa),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .out_addr  (out_addr),
        .err_cnt   (err_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [39:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sa, input logic [25:0] imm);
        in_valid = 1'b1;
        in_mnem  = mn;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_sa    = sa;
        in_imm   = imm;
    endtask

    task automatic do_reset;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        resetn    = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        exp_addr = 0;
        exp_ecnt = 0;
    endtask

    task automatic test_reset;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(40'h0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0);
        in_valid = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0 ||
            out_addr !== 10'd0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b instr=%h err=%b addr=%0d cnt=%0d, expected all zero",
                     out_valid, out_instr, out_err, out_addr, err_cnt);
        end
        tick();
        resetn = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_latency;
        drive(40'("ADDU"), 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_valid=%b one edge after accept, expected 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h00221821 || out_err !== 1'b0 || out_addr !== 10'd0) begin
            errors++;
            $display("FAIL latency_addu: valid=%b instr=%h err=%b addr=%0d, expected 1 00221821 0 0",
                     out_valid, out_instr, out_err, out_addr);
        end
        tick();
        exp_addr = 1;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 10'd1) begin
            errors++;
            $display("FAIL latency_drain: valid=%b addr=%0d, expected 0 1", out_valid, out_addr);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h34081234;
        exp_w[1] = 32'h08100000;
        exp_w[2] = 32'h0490FFFF;
        do_reset();
        drive(40'("ORI"), 5'd0, 5'd8, 5'd0, 5'd0, 26'h0001234);
        tick();
        drive(40'("J"), 5'd0, 5'd0, 5'd0, 5'd0, 26'h0100000);
        tick();
        drive(40'("BLTZAL"), 5'd4, 5'd3, 5'd0, 5'd0, 26'h000FFFF);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_instr !== exp_w[k] || out_addr !== 10'(k)) begin
                errors++;
                $display("FAIL b2b_word%0d: valid=%b instr=%h addr=%0d, expected 1 %h %0d",
                         k, out_valid, out_instr, out_addr, exp_w[k], k);
            end
            tick();
            in_valid = 1'b0;
        end
        exp_addr = 3;
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h8FBF0010;
        exp_w[1] = 32'h00094100;
        exp_w[2] = 32'h40856000;
        out_ready = 1'b0;
        drive(40'("LW"), 5'd29, 5'd31, 5'd0, 5'd0, 26'h0000010);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready0: in_ready=%b expected 1", in_ready);
        end
        tick();
        drive(40'("SLL"), 5'd0, 5'd9, 5'd8, 5'd4, 26'd0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready1: in_ready=%b expected 1", in_ready);
        end
        tick();
        drive(40'("MTOC0"), 5'd0, 5'd5, 5'd12, 5'd0, 26'd0);
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== exp_w[0] ||
                out_addr !== 10'(exp_addr)) begin
                errors++;
                $display("FAIL bp_stall%0d: in_ready=%b valid=%b instr=%h addr=%0d, expected 0 1 %h %0d",
                         s, in_ready, out_valid, out_instr, out_addr, exp_w[0], exp_addr);
            end
            if (s < 2) tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: in_ready=%b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        exp_addr++;
        for (int k = 1; k < 3; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_instr !== exp_w[k] || out_addr !== 10'(exp_addr)) begin
                errors++;
                $display("FAIL bp_drain%0d: valid=%b instr=%h addr=%0d, expected 1 %h %0d",
                         k, out_valid, out_instr, out_addr, exp_w[k], exp_addr);
            end
            tick();
            exp_addr++;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_unknown;
        do_reset();
        drive(40'("FOO"), 5'd1, 5'd2, 5'd3, 5'd4, 26'h5);
        tick();
        drive(40'("ERET"), 5'd0, 5'd0, 5'd0, 5'd0, 26'd0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h0 || out_err !== 1'b1 ||
            out_addr !== 10'd0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL unk_foo: valid=%b instr=%h err=%b addr=%0d cnt=%0d, expected 1 0 1 0 0",
                     out_valid, out_instr, out_err, out_addr, err_cnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h42000018 || out_err !== 1'b0 ||
            out_addr !== 10'd1 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL unk_eret: valid=%b instr=%h err=%b addr=%0d cnt=%0d, expected 1 42000018 0 1 1",
                     out_valid, out_instr, out_err, out_addr, err_cnt);
        end
        tick();
        exp_addr = 2;
        exp_ecnt = 1;
    endtask

    task automatic test_encode;
        logic [39:0] tm [12];
        logic [4:0]  trs [12];
        logic [4:0]  trt [12];
        logic [4:0]  trd [12];
        logic [4:0]  tsa [12];
        logic [25:0] tim [12];
        logic [31:0] tex [12];
        logic        ter [12];
        tm[0]  = 40'("SYSC");  trs[0]  = 5'd1;  trt[0]  = 5'd2; trd[0]  = 5'd3;  tsa[0]  = 5'd4; tim[0]  = 26'd0;        tex[0]  = 32'h0000000C; ter[0]  = 1'b0;
        tm[1]  = 40'("BRE");   trs[1]  = 5'd31; trt[1]  = 5'd0; trd[1]  = 5'd0;  tsa[1]  = 5'd0; tim[1]  = 26'd0;        tex[1]  = 32'h0000000D; ter[1]  = 1'b0;
        tm[2]  = 40'("JAL");   trs[2]  = 5'd0;  trt[2]  = 5'd0; trd[2]  = 5'd0;  tsa[2]  = 5'd0; tim[2]  = 26'h3FFFFFF;  tex[2]  = 32'h0FFFFFFF; ter[2]  = 1'b0;
        tm[3]  = 40'("BGEZ");  trs[3]  = 5'd3;  trt[3]  = 5'd7; trd[3]  = 5'd0;  tsa[3]  = 5'd0; tim[3]  = 26'h0008000;  tex[3]  = 32'h04618000; ter[3]  = 1'b0;
        tm[4]  = 40'("MFC0");  trs[4]  = 5'd0;  trt[4]  = 5'd2; trd[4]  = 5'd14; tsa[4]  = 5'd0; tim[4]  = 26'd0;        tex[4]  = 32'h40027000; ter[4]  = 1'b0;
        tm[5]  = 40'("LUI");   trs[5]  = 5'd0;  trt[5]  = 5'd1; trd[5]  = 5'd0;  tsa[5]  = 5'd0; tim[5]  = 26'h000ABCD;  tex[5]  = 32'h3C01ABCD; ter[5]  = 1'b0;
        tm[6]  = 40'("JALR");  trs[6]  = 5'd31; trt[6]  = 5'd0; trd[6]  = 5'd31; tsa[6]  = 5'd0; tim[6]  = 26'd0;        tex[6]  = 32'h03E0F809; ter[6]  = 1'b0;
        tm[7]  = 40'("SLTIU"); trs[7]  = 5'd2;  trt[7]  = 5'd3; trd[7]  = 5'd0;  tsa[7]  = 5'd0; tim[7]  = 26'h0000007;  tex[7]  = 32'h2C430007; ter[7]  = 1'b0;
        tm[8]  = 40'("NOP");   trs[8]  = 5'd5;  trt[8]  = 5'd5; trd[8]  = 5'd5;  tsa[8]  = 5'd5; tim[8]  = 26'h0000055;  tex[8]  = 32'h00000000; ter[8]  = 1'b0;
        tm[9]  = 40'("XYZZY"); trs[9]  = 5'd1;  trt[9]  = 5'd1; trd[9]  = 5'd1;  tsa[9]  = 5'd1; tim[9]  = 26'h0000001;  tex[9]  = 32'h00000000; ter[9]  = 1'b1;
        tm[10] = 40'("SRAV");  trs[10] = 5'd4;  trt[10] = 5'd5; trd[10] = 5'd6;  tsa[10] = 5'd0; tim[10] = 26'd0;        tex[10] = 32'h00853007; ter[10] = 1'b0;
        tm[11] = 40'("SB");    trs[11] = 5'd8;  trt[11] = 5'd9; trd[11] = 5'd0;  tsa[11] = 5'd0; tim[11] = 26'h000FFFC;  tex[11] = 32'hA109FFFC; ter[11] = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive(tm[k], trs[k], trt[k], trd[k], tsa[k], tim[k]);
            tick();
            in_valid = 1'b0;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_instr !== tex[k] || out_err !== ter[k] ||
                out_addr !== 10'(exp_addr) || err_cnt !== 8'(exp_ecnt)) begin
                errors++;
                $display("FAIL enc_%0d: valid=%b instr=%h err=%b addr=%0d cnt=%0d, expected 1 %h %b %0d %0d",
                         k, out_valid, out_instr, out_err, out_addr, err_cnt, tex[k], ter[k], exp_addr, exp_ecnt);
            end
            tick();
            exp_addr++;
            if (ter[k]) exp_ecnt++;
        end
    endtask

    task automatic stream(input logic [39:0] mn, input int n, input logic is_err);
        int sent;
        int got;
        int cyc;
        logic acc;
        logic ov;
        sent = 0;
        got  = 0;
        cyc  = 0;
        drive(mn, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0);
        out_ready = 1'b1;
        while (got < n && cyc < 4 * n + 20) begin
            in_valid = (sent < n);
            #1;
            acc = in_valid && in_ready;
            ov  = out_valid;
            if (ov) begin
                checks++;
                if (out_addr !== 10'(exp_addr) || out_err !== is_err ||
                    err_cnt !== 8'((exp_ecnt > 255) ? 255 : exp_ecnt)) begin
                    errors++;
                    $display("FAIL stream_word%0d: addr=%0d err=%b cnt=%0d, expected %0d %b %0d",
                             got, out_addr, out_err, err_cnt, exp_addr % 1024, is_err,
                             (exp_ecnt > 255) ? 255 : exp_ecnt);
                end
            end
            tick();
            cyc++;
            if (acc) sent++;
            if (ov) begin
                got++;
                exp_addr = (exp_addr + 1) % 1024;
                if (is_err) exp_ecnt++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL stream_timeout: got %0d words, expected %0d", got, n);
        end
    endtask

    task automatic test_addr_wrap;
        do_reset();
        stream(40'("NOP"), 1025, 1'b0);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 10'd1) begin
            errors++;
            $display("FAIL wrap_final: valid=%b addr=%0d, expected 0 1", out_valid, out_addr);
        end
    endtask

    task automatic test_err_saturate;
        stream(40'("QQQ"), 300, 1'b1);
        #1;
        checks++;
        if (err_cnt !== 8'd255 || out_addr !== 10'(exp_addr)) begin
            errors++;
            $display("FAIL errcnt_sat: cnt=%0d addr=%0d, expected 255 %0d", err_cnt, out_addr, exp_addr);
        end
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b0;
        drive(40'("ADDU"), 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
        tick();
        drive(40'("ORI"), 5'd0, 5'd8, 5'd0, 5'd0, 26'h0001234);
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_inflight: out_valid=%b expected 1", out_valid);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== 10'd0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b instr=%h addr=%0d cnt=%0d, expected 0 0 0 0",
                     out_valid, out_instr, out_addr, err_cnt);
        end
        tick();
        resetn    = 1'b1;
        out_ready = 1'b1;
        tick();
        drive(40'("SW"), 5'd2, 5'd3, 5'd0, 5'd0, 26'h0000004);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale: out_valid=%b expected 0 (old words must be gone)", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'hAC430004 || out_addr !== 10'd0) begin
            errors++;
            $display("FAIL mid_next: valid=%b instr=%h addr=%0d, expected 1 ac430004 0",
                     out_valid, out_instr, out_addr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_unknown();
        test_encode();
        test_addr_wrap();
        test_err_saturate();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
